// File: rtl/slurm16_cpu_wb_arbiter.sv
// slurm16_cpu_wb_arbiter
//   Shares the single register-file write port between the pipeline writeback
//   stage and an auxiliary multi-cycle result source. The pipeline always wins
//   the port. Auxiliary results are held in an in-order FIFO and written back
//   whenever the pipeline leaves a writeback slot idle (wb_sel_i == 0).
//   Decode-stage reads of a register that still has a queued write are flagged
//   as hazards.
//
//   Optional feature macro: SLURM16_WB_ARB_WAW_SQUASH_EN
//     When defined, a pipeline write to a register that also has queued FIFO
//     entries invalidates those entries, because the pipeline value is newer.
//     An invalidated entry still drains through the port, but as a no-op
//     write (rf_sel_o = 0).
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   wb_sel_i / wb_data_i      pipeline writeback (sel 0 = idle slot)
//   aux_valid_i / aux_ready_o auxiliary handshake (ready = FIFO not full)
//   aux_sel_i / aux_data_i    auxiliary destination and data
//   rf_sel_o / rf_data_o      registered register-file write port
//   rf_src_aux_o              current rf write was drained from the FIFO
//   query_a_i / query_b_i     decode read selects
//   hazard_a_o / hazard_b_o   query matches a valid queued entry (combinational)
//   fifo_count_o              occupied FIFO entries
module slurm16_cpu_wb_arbiter #(
  parameter int REGISTER_BITS = 7,
  parameter int BITS          = 16,
  parameter int DEPTH         = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [REGISTER_BITS-1:0] wb_sel_i,
  input  logic [BITS-1:0]          wb_data_i,
  input  logic                     aux_valid_i,
  output logic                     aux_ready_o,
  input  logic [REGISTER_BITS-1:0] aux_sel_i,
  input  logic [BITS-1:0]          aux_data_i,
  output logic [REGISTER_BITS-1:0] rf_sel_o,
  output logic [BITS-1:0]          rf_data_o,
  output logic                     rf_src_aux_o,
  input  logic [REGISTER_BITS-1:0] query_a_i,
  input  logic [REGISTER_BITS-1:0] query_b_i,
  output logic                     hazard_a_o,
  output logic                     hazard_b_o,
  output logic [$clog2(DEPTH):0]   fifo_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REGISTER_BITS-1:0] sel_q  [DEPTH];
  logic [BITS-1:0]          data_q [DEPTH];
  logic [DEPTH-1:0]         vld_q, vld_d;
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q;

  logic full, push, store, pop, wb_active;

  // Ready is held low during reset; a same-cycle pop never frees a slot for
  // this cycle's push, so ready depends only on the registered count.
  assign full        = (count_q == CW'(DEPTH));
  assign aux_ready_o = !full && !rst_i;
  assign push        = aux_valid_i && aux_ready_o;
  // Results addressed to r0 complete the handshake but are never stored.
  assign store       = push && (aux_sel_i != '0);
  assign wb_active   = (wb_sel_i != '0);
  assign pop         = !wb_active && (count_q != '0);

  assign fifo_count_o = count_q;

  // Hazards look only at entries present before this edge; the popped head
  // still counts since its write has not landed yet.
  always_comb begin
    hazard_a_o = 1'b0;
    hazard_b_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && (sel_q[i] == query_a_i)) hazard_a_o = 1'b1;
      if (vld_q[i] && (sel_q[i] == query_b_i)) hazard_b_o = 1'b1;
    end
    if (query_a_i == '0) hazard_a_o = 1'b0;
    if (query_b_i == '0) hazard_b_o = 1'b0;
  end

  always_comb begin
    vld_d = vld_q;
`ifdef SLURM16_WB_ARB_WAW_SQUASH_EN
    // Squash compares against pre-edge entries only, so the entry being
    // written this cycle is never squashed.
    if (wb_active) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && (sel_q[i] == wb_sel_i)) vld_d[i] = 1'b0;
      end
    end
`endif
    if (pop)   vld_d[rd_ptr_q] = 1'b0;
    if (store) vld_d[wr_ptr_q] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        sel_q[i]  <= '0;
        data_q[i] <= '0;
      end
      vld_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rf_sel_o     <= '0;
      rf_data_o    <= '0;
      rf_src_aux_o <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (store) begin
        sel_q[wr_ptr_q]  <= aux_sel_i;
        data_q[wr_ptr_q] <= aux_data_i;
      end
      wr_ptr_q <= wr_ptr_q + PW'(store);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      count_q  <= count_q + CW'(store) - CW'(pop);

      if (wb_active) begin
        rf_sel_o     <= wb_sel_i;
        rf_data_o    <= wb_data_i;
        rf_src_aux_o <= 1'b0;
      end else if (pop) begin
        // A squashed head still drains, but as a write to r0 (no-op).
        rf_sel_o     <= vld_q[rd_ptr_q] ? sel_q[rd_ptr_q] : '0;
        rf_data_o    <= data_q[rd_ptr_q];
        rf_src_aux_o <= 1'b1;
      end else begin
        rf_sel_o     <= '0;
        rf_data_o    <= '0;
        rf_src_aux_o <= 1'b0;
      end
    end
  end

endmodule
